// File: rtl/jts16_fd1089_ctrl.sv
// jts16_fd1089_ctrl
// Sequences 68000 ROM fetches through the FD1089 decryption datapath and
// routes the FD1089 key/LUT download into the decoder tables.
//
// Ports
//   clk, rst                 : system clock, synchronous active-high reset
//   downloading, prog_*      : ROM download stream (address relative to FD1089 region)
//   key_we, lut_we, cfg_*    : registered write port into key table / LUT PROM
//   tables_ok                : both tables completely loaded
//   dec_en                   : game uses decryption
//   cpu_cs/op_n/addr/data/ok : CPU ROM request and returned word
//   rom_cs/data/ok           : SDRAM ROM port
//   dec_op_n/addr/enc        : context and encrypted word presented to the decoder
//   dec_word                 : decoder output, one cycle behind dec_enc/dec_addr
//   dec_active               : decoder enable (dec_en & tables_ok)
//
// state | meaning
// IDLE  | waiting for a CPU request; cache lookup
// FETCH | SDRAM read outstanding
// LUT   | decoder PROM read in flight
// LATCH | decoded word captured into cpu_data and cache
// DONE  | cpu_ok asserted until the request goes away or changes
module jts16_fd1089_ctrl #(
    parameter logic [12:0] KEY_END = 13'h1FFF
) (
    input  logic        rst,
    input  logic        clk,
    input  logic        downloading,
    input  logic        prog_we,
    input  logic [13:0] prog_addr,
    input  logic [7:0]  prog_data,
    output logic        key_we,
    output logic        lut_we,
    output logic [12:0] cfg_addr,
    output logic [7:0]  cfg_data,
    output logic        tables_ok,
    input  logic        dec_en,
    input  logic        cpu_cs,
    input  logic        cpu_op_n,
    input  logic [22:0] cpu_addr,
    output logic [15:0] cpu_data,
    output logic        cpu_ok,
    output logic        rom_cs,
    input  logic [15:0] rom_data,
    input  logic        rom_ok,
    output logic        dec_op_n,
    output logic [22:0] dec_addr,
    output logic [15:0] dec_enc,
    input  logic [15:0] dec_word,
    output logic        dec_active
);

    typedef enum logic [2:0] {IDLE, FETCH, LUT, LATCH, DONE} state_t;

    localparam logic [13:0] KEY_LAST  = {1'b0, KEY_END};
    localparam logic [13:0] LUT_FIRST = KEY_LAST + 14'd1;
    localparam logic [13:0] LUT_LAST  = KEY_LAST + 14'd256;

    state_t      state_q, state_d;
    logic        key_we_q, key_we_d, lut_we_q, lut_we_d;
    logic [12:0] cfg_addr_q, cfg_addr_d;
    logic [7:0]  cfg_data_q, cfg_data_d;
    logic        key_done_q, key_done_d, lut_done_q, lut_done_d;
    logic        dl_q, dl_d;
    logic        act_q, act_d;
    logic        dec_op_n_q, dec_op_n_d;
    logic [22:0] dec_addr_q, dec_addr_d;
    logic [15:0] dec_enc_q, dec_enc_d;
    logic [15:0] cpu_data_q, cpu_data_d;
    logic        cache_valid_q, cache_valid_d;
    logic [23:0] cache_tag_q, cache_tag_d;
    logic [15:0] cache_word_q, cache_word_d;

    logic        in_key, in_lut, dl_rise, act_chg, hit, abort, start;
    logic        fetch_ok, latch_ok;
    logic [7:0]  lut_off;
    logic [23:0] tag_in, tag_lat;

    assign in_key     = prog_addr <= KEY_LAST;
    assign in_lut     = (prog_addr >= LUT_FIRST) && (prog_addr <= LUT_LAST);
    // LUT span is exactly 256 bytes, so the low byte difference is the offset
    assign lut_off    = prog_addr[7:0] - LUT_FIRST[7:0];
    assign dl_rise    = downloading & ~dl_q;

    assign tables_ok  = key_done_q & lut_done_q;
    assign dec_active = dec_en & tables_ok;
    assign act_chg    = dec_active != act_q;

    assign tag_in   = {cpu_op_n, cpu_addr};
    assign tag_lat  = {dec_op_n_q, dec_addr_q};
    // a fill taken under a different dec_active setting must never hit
    assign hit      = cache_valid_q & ~act_chg & (cache_tag_q == tag_in);
    assign abort    = ~cpu_cs | prog_we;
    // a download byte in the same cycle as a CPU request takes priority
    assign start    = (state_q == IDLE) & ~downloading & ~prog_we & cpu_cs;
    assign fetch_ok = (state_q == FETCH) & ~abort & rom_ok;
    assign latch_ok = (state_q == LATCH) & ~abort;

    // state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = hit ? DONE : FETCH;
            FETCH:   if (abort) state_d = IDLE;
                     else if (rom_ok) state_d = dec_active ? LUT : DONE;
            LUT:     state_d = abort ? IDLE : LATCH;
            LATCH:   state_d = abort ? IDLE : DONE;
            DONE:    if (!cpu_cs || tag_in != tag_lat) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        rom_cs = 1'b0;
        cpu_ok = 1'b0;
        case (state_q)
            FETCH:   rom_cs = 1'b1;
            DONE:    cpu_ok = 1'b1;
            default: ;
        endcase
    end

    // datapath and download next values
    always_comb begin
        key_we_d   = prog_we & in_key;
        lut_we_d   = prog_we & in_lut;
        cfg_addr_d = cfg_addr_q;
        cfg_data_d = cfg_data_q;
        if (prog_we && in_key) begin
            cfg_addr_d = prog_addr[12:0];
            cfg_data_d = prog_data;
        end else if (prog_we && in_lut) begin
            cfg_addr_d = {5'd0, lut_off};
            cfg_data_d = prog_data;
        end

        key_done_d = key_done_q;
        lut_done_d = lut_done_q;
        if (dl_rise) begin
            key_done_d = 1'b0;
            lut_done_d = 1'b0;
        end else if (prog_we) begin
            if (prog_addr == KEY_LAST) key_done_d = 1'b1;
            if (prog_addr == LUT_LAST) lut_done_d = 1'b1;
        end
        dl_d  = downloading;
        act_d = dec_active;

        dec_op_n_d   = dec_op_n_q;
        dec_addr_d   = dec_addr_q;
        dec_enc_d    = dec_enc_q;
        cpu_data_d   = cpu_data_q;
        cache_tag_d  = cache_tag_q;
        cache_word_d = cache_word_q;
        if (start) begin
            {dec_op_n_d, dec_addr_d} = tag_in;
            if (hit) cpu_data_d = cache_word_q;
        end
        if (fetch_ok) begin
            dec_enc_d = rom_data;
            if (!dec_active) cpu_data_d = rom_data;
        end
        if (latch_ok) begin
            cpu_data_d   = dec_word;
            cache_word_d = dec_word;
            cache_tag_d  = tag_lat;
        end

        cache_valid_d = cache_valid_q;
        if (prog_we || act_chg) cache_valid_d = 1'b0;
        else if (latch_ok)      cache_valid_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            key_we_q      <= 1'b0;
            lut_we_q      <= 1'b0;
            cfg_addr_q    <= '0;
            cfg_data_q    <= '0;
            key_done_q    <= 1'b0;
            lut_done_q    <= 1'b0;
            dl_q          <= 1'b0;
            act_q         <= 1'b0;
            dec_op_n_q    <= 1'b0;
            dec_addr_q    <= '0;
            dec_enc_q     <= '0;
            cpu_data_q    <= '0;
            cache_valid_q <= 1'b0;
            cache_tag_q   <= '0;
            cache_word_q  <= '0;
        end else begin
            key_we_q      <= key_we_d;
            lut_we_q      <= lut_we_d;
            cfg_addr_q    <= cfg_addr_d;
            cfg_data_q    <= cfg_data_d;
            key_done_q    <= key_done_d;
            lut_done_q    <= lut_done_d;
            dl_q          <= dl_d;
            act_q         <= act_d;
            dec_op_n_q    <= dec_op_n_d;
            dec_addr_q    <= dec_addr_d;
            dec_enc_q     <= dec_enc_d;
            cpu_data_q    <= cpu_data_d;
            cache_valid_q <= cache_valid_d;
            cache_tag_q   <= cache_tag_d;
            cache_word_q  <= cache_word_d;
        end
    end

    assign key_we   = key_we_q;
    assign lut_we   = lut_we_q;
    assign cfg_addr = cfg_addr_q;
    assign cfg_data = cfg_data_q;
    assign dec_op_n = dec_op_n_q;
    assign dec_addr = dec_addr_q;
    assign dec_enc  = dec_enc_q;
    assign cpu_data = cpu_data_q;

endmodule

// File: tb/tb_jts16_fd1089_ctrl.sv
module tb_jts16_fd1089_ctrl;

    logic        rst, clk;
    logic        downloading, prog_we;
    logic [13:0] prog_addr;
    logic [7:0]  prog_data;
    logic        key_we, lut_we;
    logic [12:0] cfg_addr;
    logic [7:0]  cfg_data;
    logic        tables_ok, dec_en, cpu_cs, cpu_op_n;
    logic [22:0] cpu_addr;
    logic [15:0] cpu_data;
    logic        cpu_ok, rom_cs;
    logic [15:0] rom_data;
    logic        rom_ok, dec_op_n;
    logic [22:0] dec_addr;
    logic [15:0] dec_enc, dec_word;
    logic        dec_active;

    int nvec = 0;
    int nerr = 0;

    jts16_fd1089_ctrl #(.KEY_END(13'h1FFF)) dut (
        .rst(rst), .clk(clk), .downloading(downloading), .prog_we(prog_we),
        .prog_addr(prog_addr), .prog_data(prog_data), .key_we(key_we),
        .lut_we(lut_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .tables_ok(tables_ok), .dec_en(dec_en), .cpu_cs(cpu_cs),
        .cpu_op_n(cpu_op_n), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
        .cpu_ok(cpu_ok), .rom_cs(rom_cs), .rom_data(rom_data), .rom_ok(rom_ok),
        .dec_op_n(dec_op_n), .dec_addr(dec_addr), .dec_enc(dec_enc),
        .dec_word(dec_word), .dec_active(dec_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Decoder stand-in with one clock of PROM latency:
    // word = enc ^ addr[15:0] ^ (op_n ? 5A5A : A5A5)
    always @(posedge clk)
        dec_word <= dec_enc ^ dec_addr[15:0] ^ (dec_op_n ? 16'h5A5A : 16'hA5A5);

    // advance one clock; inputs change and outputs are sampled 1 ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; downloading = 1'b0; prog_we = 1'b0; prog_addr = '0;
        prog_data = '0; dec_en = 1'b1; cpu_cs = 1'b0; cpu_op_n = 1'b0;
        cpu_addr = '0; rom_data = '0; rom_ok = 1'b0;
        tick(); tick();
        rst = 1'b0;
        nvec++;
        if ({key_we, lut_we, cfg_addr, cfg_data, tables_ok} !== 24'd0) begin
            $display("FAIL reset_cfg: got %h want 0", {key_we, lut_we, cfg_addr, cfg_data, tables_ok}); nerr++;
        end
        nvec++;
        if ({cpu_data, cpu_ok, rom_cs, dec_op_n, dec_addr, dec_enc, dec_active} !== 60'd0) begin
            $display("FAIL reset_cpu: got %h want 0", {cpu_data, cpu_ok, rom_cs, dec_op_n, dec_addr, dec_enc, dec_active}); nerr++;
        end
    endtask

    task automatic test_download();
        int nkey = 0;
        int nlut = 0;
        downloading = 1'b1;
        tick();
        for (int i = 0; i <= 14'h20FF; i++) begin
            prog_we = 1'b1; prog_addr = 14'(i); prog_data = 8'(i) ^ 8'h3C;
            tick();
            if (key_we) nkey++;
            if (lut_we) nlut++;
            if (i == 14'h2005) begin
                nvec++;
                if ({cfg_addr, cfg_data} !== {13'h0005, 8'h39}) begin
                    $display("FAIL lut_cfg: got %h/%h want 0005/39", cfg_addr, cfg_data); nerr++;
                end
            end
            if (i == 14'h1234) begin
                nvec++;
                if ({key_we, cfg_addr, cfg_data} !== {1'b1, 13'h1234, 8'h08}) begin
                    $display("FAIL key_cfg: got %b %h/%h want 1 1234/08", key_we, cfg_addr, cfg_data); nerr++;
                end
            end
            if (i == 14'h20FE) begin
                nvec++;
                if (tables_ok !== 1'b0) begin
                    $display("FAIL tables_early: got %b want 0", tables_ok); nerr++;
                end
            end
        end
        nvec++;
        if (tables_ok !== 1'b1) begin
            $display("FAIL tables_ok: got %b want 1", tables_ok); nerr++;
        end
        nvec++;
        if (nkey != 8192) begin
            $display("FAIL key_count: got %0d want 8192", nkey); nerr++;
        end
        nvec++;
        if (nlut != 256) begin
            $display("FAIL lut_count: got %0d want 256", nlut); nerr++;
        end
        prog_addr = 14'h2100;
        tick();
        nvec++;
        if ({key_we, lut_we} !== 2'b00) begin
            $display("FAIL beyond_lut: got %b want 00", {key_we, lut_we}); nerr++;
        end
        prog_we = 1'b0; downloading = 1'b0;
        tick();
    endtask

    task automatic test_decrypt_miss();
        cpu_cs = 1'b1; cpu_op_n = 1'b0; cpu_addr = 23'h000100;
        tick();
        nvec++;
        if ({rom_cs, cpu_ok, dec_op_n, dec_addr, dec_active} !== {2'b10, 1'b0, 23'h000100, 1'b1}) begin
            $display("FAIL miss_fetch: got %b%b %b %h %b want 10 0 000100 1", rom_cs, cpu_ok, dec_op_n, dec_addr, dec_active); nerr++;
        end
        tick(); tick(); tick(); tick();
        rom_ok = 1'b1; rom_data = 16'h1234;
        tick();
        rom_ok = 1'b0; rom_data = 16'hDEAD;
        nvec++;
        if ({dec_enc, rom_cs, cpu_ok} !== {16'h1234, 2'b00}) begin
            $display("FAIL miss_lut: got %h %b%b want 1234 00", dec_enc, rom_cs, cpu_ok); nerr++;
        end
        tick();
        nvec++;
        if ({dec_enc, dec_addr, cpu_ok} !== {16'h1234, 23'h000100, 1'b0}) begin
            $display("FAIL miss_latch: got %h %h %b want 1234 000100 0", dec_enc, dec_addr, cpu_ok); nerr++;
        end
        tick();
        nvec++;
        if ({cpu_ok, cpu_data} !== {1'b1, 16'hB691}) begin
            $display("FAIL miss_done: got %b %h want 1 b691", cpu_ok, cpu_data); nerr++;
        end
        tick(); tick();
        nvec++;
        if ({cpu_ok, cpu_data} !== {1'b1, 16'hB691}) begin
            $display("FAIL miss_hold: got %b %h want 1 b691", cpu_ok, cpu_data); nerr++;
        end
        cpu_cs = 1'b0;
        tick();
        nvec++;
        if (cpu_ok !== 1'b0) begin
            $display("FAIL miss_release: got %b want 0", cpu_ok); nerr++;
        end
    endtask

    task automatic test_hit();
        cpu_cs = 1'b1; cpu_op_n = 1'b0; cpu_addr = 23'h000100;
        tick();
        nvec++;
        if ({cpu_ok, rom_cs, cpu_data} !== {2'b10, 16'hB691}) begin
            $display("FAIL hit: got %b%b %h want 10 b691", cpu_ok, rom_cs, cpu_data); nerr++;
        end
        cpu_cs = 1'b0;
        tick();
        cpu_cs = 1'b1; cpu_op_n = 1'b1;
        tick();
        nvec++;
        if ({rom_cs, cpu_ok} !== 2'b10) begin
            $display("FAIL data_tag_miss: got %b%b want 10", rom_cs, cpu_ok); nerr++;
        end
        rom_ok = 1'b1; rom_data = 16'h1234;
        tick();
        rom_ok = 1'b0;
        tick(); tick();
        nvec++;
        if ({cpu_ok, cpu_data} !== {1'b1, 16'h496E}) begin
            $display("FAIL data_read: got %b %h want 1 496e", cpu_ok, cpu_data); nerr++;
        end
        cpu_cs = 1'b0;
        tick();
    endtask

    task automatic test_bypass();
        dec_en = 1'b0;
        cpu_cs = 1'b1; cpu_op_n = 1'b0; cpu_addr = 23'h000200;
        tick();
        nvec++;
        if ({dec_active, rom_cs} !== 2'b01) begin
            $display("FAIL bypass_fetch: got %b%b want 01", dec_active, rom_cs); nerr++;
        end
        rom_ok = 1'b1; rom_data = 16'hBEEF;
        tick();
        rom_ok = 1'b0;
        nvec++;
        if ({cpu_ok, rom_cs, cpu_data} !== {2'b10, 16'hBEEF}) begin
            $display("FAIL bypass_done: got %b%b %h want 10 beef", cpu_ok, rom_cs, cpu_data); nerr++;
        end
        cpu_cs = 1'b0; dec_en = 1'b1;
        tick();
    endtask

    // full decrypted read at addr (op_n=0) with given SDRAM word; checks the returned word
    task automatic do_read(input logic [22:0] a, input logic [15:0] w, input logic [15:0] exp);
        cpu_cs = 1'b1; cpu_op_n = 1'b0; cpu_addr = a;
        tick();
        rom_ok = 1'b1; rom_data = w;
        tick();
        rom_ok = 1'b0;
        tick(); tick();
        nvec++;
        if ({cpu_ok, cpu_data} !== {1'b1, exp}) begin
            $display("FAIL read_%h: got %b %h want 1 %h", a, cpu_ok, cpu_data, exp); nerr++;
        end
        cpu_cs = 1'b0;
        tick();
    endtask

    task automatic test_abort_lut();
        do_read(23'h000300, 16'h1111, 16'hB7B4);
        cpu_cs = 1'b1; cpu_addr = 23'h000400;
        tick();
        rom_ok = 1'b1; rom_data = 16'h0F0F;
        tick();
        rom_ok = 1'b0; cpu_cs = 1'b0;
        tick();
        tick(); tick();
        nvec++;
        if ({cpu_ok, rom_cs} !== 2'b00) begin
            $display("FAIL abort_lut: got %b%b want 00", cpu_ok, rom_cs); nerr++;
        end
        cpu_cs = 1'b1; cpu_addr = 23'h000300;
        tick();
        nvec++;
        if ({cpu_ok, cpu_data} !== {1'b1, 16'hB7B4}) begin
            $display("FAIL abort_keeps_cache: got %b %h want 1 b7b4", cpu_ok, cpu_data); nerr++;
        end
        cpu_cs = 1'b0;
        tick();
        do_read(23'h000400, 16'h0F0F, 16'hAEAA);
    endtask

    task automatic test_prog_we();
        cpu_cs = 1'b1; cpu_addr = 23'h000600;
        tick();
        prog_we = 1'b1; prog_addr = 14'h3000;
        tick();
        prog_we = 1'b0;
        nvec++;
        if ({rom_cs, cpu_ok, key_we, lut_we, tables_ok} !== 5'b00001) begin
            $display("FAIL prog_abort: got %b want 00001", {rom_cs, cpu_ok, key_we, lut_we, tables_ok}); nerr++;
        end
        cpu_cs = 1'b0;
        tick();
        // simultaneous request and download byte: download wins
        cpu_cs = 1'b1; cpu_addr = 23'h000400; prog_we = 1'b1;
        tick();
        prog_we = 1'b0;
        nvec++;
        if ({rom_cs, cpu_ok} !== 2'b00) begin
            $display("FAIL cs_and_prog: got %b%b want 00", rom_cs, cpu_ok); nerr++;
        end
        tick();
        nvec++;
        if ({rom_cs, cpu_ok} !== 2'b10) begin
            $display("FAIL prog_invalidates: got %b%b want 10", rom_cs, cpu_ok); nerr++;
        end
        rom_ok = 1'b1; rom_data = 16'h0F0F;
        tick();
        rom_ok = 1'b0;
        tick(); tick();
        nvec++;
        if ({cpu_ok, cpu_data} !== {1'b1, 16'hAEAA}) begin
            $display("FAIL refetch: got %b %h want 1 aeaa", cpu_ok, cpu_data); nerr++;
        end
        cpu_cs = 1'b0;
        tick();
    endtask

    task automatic test_reset_latch();
        cpu_cs = 1'b1; cpu_addr = 23'h000500;
        tick();
        rom_ok = 1'b1; rom_data = 16'h2222;
        tick();
        rom_ok = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; cpu_cs = 1'b0;
        nvec++;
        if ({cpu_ok, rom_cs, cpu_data, dec_enc, dec_addr, tables_ok} !== 58'd0) begin
            $display("FAIL reset_latch: got %h want 0", {cpu_ok, rom_cs, cpu_data, dec_enc, dec_addr, tables_ok}); nerr++;
        end
        tick();
        cpu_cs = 1'b1; cpu_addr = 23'h000400;
        tick();
        nvec++;
        if ({rom_cs, cpu_ok} !== 2'b10) begin
            $display("FAIL post_reset_miss: got %b%b want 10", rom_cs, cpu_ok); nerr++;
        end
        cpu_cs = 1'b0;
        tick();
    endtask

    task automatic test_download_restart();
        downloading = 1'b1;
        tick();
        prog_we = 1'b1; prog_addr = 14'h1FFF;
        tick();
        prog_addr = 14'h20FF;
        tick();
        prog_we = 1'b0;
        nvec++;
        if (tables_ok !== 1'b1) begin
            $display("FAIL flags_set: got %b want 1", tables_ok); nerr++;
        end
        downloading = 1'b0;
        tick();
        downloading = 1'b1;
        tick();
        nvec++;
        if (tables_ok !== 1'b0) begin
            $display("FAIL dl_rise_clear: got %b want 0", tables_ok); nerr++;
        end
        downloading = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_download();
        test_decrypt_miss();
        test_hit();
        test_bypass();
        test_abort_lut();
        test_prog_we();
        test_reset_latch();
        test_download_restart();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
